// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline run-control block: sequencer states,
// the per-pipe-register control bundle and a few canned control patterns.
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      STEP   = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Write enable and bubble-insert bits for the four pipeline registers.
   // The PC write enable always tracks ifid_we, so it is derived, not stored.
   typedef struct packed {
      logic ifid_we;
      logic idex_we;
      logic exmem_we;
      logic memwb_we;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
   } ctrl_t;

   // Whole pipe frozen: nothing is written, so nothing is flushed either.
   localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};

   // Normal advance.
   localparam ctrl_t CTRL_RUN = '{ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
                                  memwb_we: 1'b1, ifid_flush: 1'b0,
                                  idex_flush: 1'b0, exmem_flush: 1'b0};

   // Taken branch in MEM: the three younger instructions are wrong-path.
   localparam ctrl_t CTRL_SQUASH = '{ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
                                     memwb_we: 1'b1, ifid_flush: 1'b1,
                                     idex_flush: 1'b1, exmem_flush: 1'b0 | 1'b1};

   // Load-use: hold PC and IF/ID, drop a bubble into ID/EX, let the load go on.
   localparam ctrl_t CTRL_BUBBLE = '{ifid_we: 1'b0, idex_we: 1'b1, exmem_we: 1'b1,
                                     memwb_we: 1'b1, ifid_flush: 1'b0,
                                     idex_flush: 1'b1, exmem_flush: 1'b0};

   // True when a source operand that is actually read matches a non-zero
   // destination ($0 is hardwired, so it never creates a dependency).
   function automatic logic src_hit(input logic [4:0] dst,
                                    input logic [4:0] src,
                                    input logic       uses);
      return uses && (dst == src) && (dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the run-control
// sequencer (slave). Clock and reset stay outside as plain ports.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();

   // Hazard detection inputs
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             id_uses_rs_i;
   logic             id_uses_rt_i;
   logic             ex_memread_i;
   logic [4:0]       ex_rd_i;
   logic             br_taken_i;
   logic             dmem_busy_i;

   // Debug and counter control
   logic             halt_req_i;
   logic             step_i;
   logic             resume_i;
   logic             clr_cnt_i;

   // Pipeline control outputs
   logic             pc_we_o;
   logic             ifid_we_o;
   logic             idex_we_o;
   logic             exmem_we_o;
   logic             memwb_we_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             exmem_flush_o;

   // Status
   logic             halted_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
             ex_memread_i, ex_rd_i, br_taken_i, dmem_busy_i,
             halt_req_i, step_i, resume_i, clr_cnt_i,
      input  pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
             ifid_flush_o, idex_flush_o, exmem_flush_o,
             halted_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
             ex_memread_i, ex_rd_i, br_taken_i, dmem_busy_i,
             halt_req_i, step_i, resume_i, clr_cnt_i,
      output pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
             ifid_flush_o, idex_flush_o, exmem_flush_o,
             halted_o, stall_cnt_o, flush_cnt_o
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Count register: reset and clear both win over an increment.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/run-control sequencer for the 5-stage pipeline: load-use
// bubbles, taken-branch squash, data-memory freeze, debug halt/step/resume
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter bit RST_HALT = 1'b0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   pipe_hazard_ctrl_if.slave  bus
);

   localparam state_t RST_STATE = RST_HALT ? HALTED : RUN;

   state_t           state;
   state_t           state_nxt;
   logic             advance;
   logic             loaduse;
   ctrl_t            ctrl;
   logic             stall_inc;
   logic             flush_inc;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Sequencer state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RST_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: halt only from RUN, step/resume only from HALTED,
   // STEP retires after exactly one advancing cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      state_nxt = state;
      unique case (state)
         RUN: begin
            if (bus.halt_req_i) state_nxt = HALTED;
         end
         HALTED: begin
            if (bus.resume_i)    state_nxt = RUN;
            else if (bus.step_i) state_nxt = STEP;
         end
         STEP: begin
            if (!bus.dmem_busy_i) state_nxt = HALTED;
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   // Pipe control in priority order: freeze, branch squash, load-use bubble,
   // normal run. A squashed load cannot cause a hazard, hence branch first.
   always_comb begin
      advance   = ((state == RUN) || (state == STEP)) && !bus.dmem_busy_i;
      loaduse   = bus.ex_memread_i &&
                  (src_hit(bus.ex_rd_i, bus.id_rs_i, bus.id_uses_rs_i) ||
                   src_hit(bus.ex_rd_i, bus.id_rt_i, bus.id_uses_rt_i));
      ctrl      = CTRL_FREEZE;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (rst_i) begin
         ctrl = CTRL_FREEZE;
      end else if (!advance) begin
         // Frozen by memory wait counts as a stall; sitting halted does not.
         stall_inc = (state != HALTED);
      end else if (bus.br_taken_i) begin
         ctrl      = CTRL_SQUASH;
         flush_inc = 1'b1;
      end else if (loaduse) begin
         ctrl      = CTRL_BUBBLE;
         stall_inc = 1'b1;
      end else begin
         ctrl = CTRL_RUN;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .inc (stall_inc),
      .clr (bus.clr_cnt_i),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .inc (flush_inc),
      .clr (bus.clr_cnt_i),
      .cnt (flush_cnt)
   );

   assign bus.pc_we_o       = ctrl.ifid_we;
   assign bus.ifid_we_o     = ctrl.ifid_we;
   assign bus.idex_we_o     = ctrl.idex_we;
   assign bus.exmem_we_o    = ctrl.exmem_we;
   assign bus.memwb_we_o    = ctrl.memwb_we;
   assign bus.ifid_flush_o  = ctrl.ifid_flush;
   assign bus.idex_flush_o  = ctrl.idex_flush;
   assign bus.exmem_flush_o = ctrl.exmem_flush;
   assign bus.halted_o      = (state == HALTED);
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.flush_cnt_o   = flush_cnt;

endmodule
